// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared types and constants for the menu cursor controller
package menu_pkg;

  localparam int N_ITEMS = 4;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_NAV      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } menu_state_t;

  typedef enum logic [1:0] {
    FIGHT  = 2'd0,
    ACTION = 2'd1,
    ITEM   = 2'd2,
    MERCY  = 2'd3
  } menu_item_t;

  function automatic logic [1:0] pos_left(input logic [1:0] pos);
    return (pos == 2'd0) ? 2'(N_ITEMS - 1) : pos - 2'd1;
  endfunction

  function automatic logic [1:0] pos_right(input logic [1:0] pos);
    return (pos == 2'(N_ITEMS - 1)) ? 2'd0 : pos + 2'd1;
  endfunction

endpackage

// File: rtl/menu_cursor_ctrl_if.sv
// rtl/menu_cursor_ctrl_if.sv - button/selection bundle between the menu and its driver
interface menu_cursor_ctrl_if;
  import menu_pkg::*;

  logic       enable;
  logic       left;
  logic       right;
  logic       select;
  logic       ack;
  logic [1:0] cursor_position;
  logic       select_valid;
  logic [1:0] select_item;

  modport master (
    output enable, left, right, select, ack,
    input  cursor_position, select_valid, select_item
  );

  modport slave (
    input  enable, left, right, select, ack,
    output cursor_position, select_valid, select_item
  );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop sync, level debounce and press pulse for one button
module button_debouncer #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // press is registered alongside the level flip so the consumer acts one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/menu_cursor_ctrl.sv
// rtl/menu_cursor_ctrl.sv - four-entry menu cursor with debounced buttons and select handshake
module menu_cursor_ctrl
  import menu_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int N_ITEMS   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_select,
  input  logic       i_ack,
  output logic [1:0] o_cursor_position,
  output logic       o_select_valid,
  output logic [1:0] o_select_item
);
  logic        left_press;
  logic        right_press;
  logic        select_press;
  menu_state_t state;
  logic [1:0]  pos;
  logic [1:0]  item;
  logic        valid;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clk(i_clk), .rst_n(i_rst_n), .raw(i_left), .press(left_press)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clk(i_clk), .rst_n(i_rst_n), .raw(i_right), .press(right_press)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_select (
    .clk(i_clk), .rst_n(i_rst_n), .raw(i_select), .press(select_press)
  );

  // Wrap helpers assume a 4-entry menu; N_ITEMS only documents that.
  localparam logic [1:0] LAST_ITEM = 2'(N_ITEMS - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_DISABLED;
      pos   <= FIGHT;
      item  <= FIGHT;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_DISABLED: begin
          if (i_enable) state <= ST_NAV;
        end
        ST_NAV: begin
          if (!i_enable) begin
            state <= ST_DISABLED;
            valid <= 1'b0;
          end else if (select_press) begin
            item  <= pos;
            valid <= 1'b1;
            state <= ST_WAIT_ACK;
          end else if (left_press && !right_press) begin
            pos <= pos_left(pos);
          end else if (right_press && !left_press) begin
            pos <= (pos == LAST_ITEM) ? 2'd0 : pos_right(pos);
          end
        end
        ST_WAIT_ACK: begin
          if (!i_enable) begin
            state <= ST_DISABLED;
            valid <= 1'b0;
          end else if (i_ack) begin
            valid <= 1'b0;
            state <= ST_NAV;
          end
        end
        default: begin
          state <= ST_DISABLED;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_cursor_position = pos;
  assign o_select_valid    = valid;
  assign o_select_item     = item;
endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// tb/tb_menu_cursor_ctrl.sv - scoreboard bench for menu_cursor_ctrl with DB_CYCLES=4
module tb_menu_cursor_ctrl;
  localparam int DB = 4;
  localparam int LAT = DB + 2;

  typedef struct {
    int kind;   // 0 cursor move, 1 select raised, 2 select cleared
    int val;
    int edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  menu_cursor_ctrl_if bus ();

  menu_cursor_ctrl #(.DB_CYCLES(DB), .N_ITEMS(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(bus.enable),
    .i_left(bus.left),
    .i_right(bus.right),
    .i_select(bus.select),
    .i_ack(bus.ack),
    .o_cursor_position(bus.cursor_position),
    .o_select_valid(bus.select_valid),
    .o_select_item(bus.select_item)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int val, input int edge_n);
    exp_t e;
    e.kind = kind;
    e.val = val;
    e.edge_n = edge_n;
    q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int val);
    exp_t e;
    total++;
    assert (q.size() > 0) else begin
      bad++;
      $error("FAIL unexpected_event: observed kind=%0d val=%0d expected=none", kind, val);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_val", val, e.val);
      check("event_edge", cyc, e.edge_n);
    end
  endtask

  logic [1:0] last_pos = 2'd0;
  logic       last_valid = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cursor_position !== last_pos) pop_check(0, int'(bus.cursor_position));
      if (bus.select_valid !== last_valid)
        pop_check(bus.select_valid ? 1 : 2, bus.select_valid ? int'(bus.select_item) : 0);
    end
    last_pos = bus.cursor_position;
    last_valid = bus.select_valid;
  end

  // Drives raw lines (bit0 left, bit1 right, bit2 select) from a negedge; hold/gap in cycles.
  task automatic press(input logic [2:0] btn, input int hold, input int gap);
    bus.left = btn[0];
    bus.right = btn[1];
    bus.select = btn[2];
    repeat (hold) @(negedge clk);
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.select = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_expect_move(input logic [2:0] btn, input int new_pos);
    push(0, new_pos, cyc + 1 + LAT);
    press(btn, 10, 10);
  endtask

  task automatic press_expect_select(input logic [2:0] btn, input int sel_item);
    push(1, sel_item, cyc + 1 + LAT);
    press(btn, 10, 10);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.select = 1'b0;
    bus.ack = 1'b0;
    #1;
    check("reset_pos", int'(bus.cursor_position), 0);
    check("reset_valid", int'(bus.select_valid), 0);
    check("reset_item", int'(bus.select_item), 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);

    press_expect_move(3'b010, 1);
    press_expect_move(3'b010, 2);
    press_expect_move(3'b010, 3);
    press_expect_move(3'b010, 0);

    press_expect_move(3'b001, 3);
    press_expect_move(3'b001, 2);

    press(3'b010, 3, 15);
    check("glitch_pos", int'(bus.cursor_position), 2);

    press_expect_select(3'b100, 2);
    check("sel_valid", int'(bus.select_valid), 1);
    check("sel_item", int'(bus.select_item), 2);
    press(3'b010, 10, 10);
    check("pending_pos", int'(bus.cursor_position), 2);
    push(2, 0, cyc + 1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check("ack_valid", int'(bus.select_valid), 0);
    repeat (3) @(negedge clk);
    press_expect_move(3'b010, 3);

    press(3'b011, 10, 10);
    check("lr_same_pos", int'(bus.cursor_position), 3);
    press_expect_move(3'b001, 2);
    press_expect_move(3'b001, 1);
    press_expect_select(3'b110, 1);
    check("selr_item", int'(bus.select_item), 1);
    check("selr_pos", int'(bus.cursor_position), 1);
    push(2, 0, cyc + 1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);

    press_expect_select(3'b100, 1);
    push(2, 0, cyc + 1);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_valid", int'(bus.select_valid), 0);
    check("dis_pos", int'(bus.cursor_position), 1);
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);

    bus.right = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("queue_drained", q.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pos", int'(bus.cursor_position), 0);
    check("rst_valid", int'(bus.select_valid), 0);
    check("rst_item", int'(bus.select_item), 0);
    bus.right = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
